bcd_adjust_ctrl: RTL and testbench

//  Multi-cycle sequencer for the x86 decimal-adjust ops DAA/DAS (and AAA/AAS optionally) in the execute stage.

---
 rtl/bcd_adjust_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_bcd_adjust_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_adjust_ctrl.sv
// -----------------------------------------------------------------------------
// bcd_adjust_ctrl
//   Multi-cycle sequencer for the x86 decimal-adjust instructions DAA/DAS (and
//   AAA/AAS when BCD_ASCII_ADJUST_EN is defined). It borrows the execute
//   stage's shared 8-bit adder/subtractor for one low-nibble step and one high
//   step. It then holds the adjusted result and flag write enables until
//   writeback accepts them.
//
//   Sequence: IDLE -> LOW -> HIGH -> DONE. An accept in DONE goes straight to
//   LOW, so back-to-back requests issue one every three cycles.
//
// Configuration macro:
//   BCD_ASCII_ADJUST_EN  defined     : AAA/AAS adjust AL/AH and set CF/AF.
//                        not defined : ops 10/11 take the same latency with
//                                      add_b = 0 and pass the operands through
//                                      unchanged (out_set_eflags = 0).
//
// Parameters:
//   FLAG_W          width of out_set_eflags
//                   (bit0 CF, bit1 PF, bit2 AF, bit3 ZF, bit4 SF, bit5 OF)
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   in_valid/ready  request handshake; in_op 00 DAA, 01 DAS, 10 AAA, 11 AAS
//   in_al, in_ah    AL / AH operands; in_cf, in_af current CF / AF
//   add_a, add_b    shared adder operands; add_sub 1 = a-b, 0 = a+b
//   add_sum         adder result (combinational); add_cout carry/borrow out
//   out_valid/ready result handshake
//   out_al, out_ah  adjusted AL / AH; out_cf, out_af new CF / AF
//   out_set_eflags  flag write enables
// -----------------------------------------------------------------------------
module bcd_adjust_ctrl #(
  parameter int FLAG_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [7:0]        in_al,
  input  logic [7:0]        in_ah,
  input  logic              in_cf,
  input  logic              in_af,
  output logic [7:0]        add_a,
  output logic [7:0]        add_b,
  output logic              add_sub,
  input  logic [7:0]        add_sum,
  input  logic              add_cout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_al,
  output logic [7:0]        out_ah,
  output logic              out_cf,
  output logic              out_af,
  output logic [FLAG_W-1:0] out_set_eflags
);

  localparam int DATA_W = 8;

`ifdef BCD_ASCII_ADJUST_EN
  localparam logic ASCII_EN = 1'b1;
`else
  localparam logic ASCII_EN = 1'b0;
`endif

  localparam logic [FLAG_W-1:0] EF_DEC = FLAG_W'(6'b011111);
  localparam logic [FLAG_W-1:0] EF_ASC = FLAG_W'(6'b000101);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Low-step correction: +/-06h when the low nibble needs adjusting.
  function automatic logic [DATA_W-1:0] low_adj(input logic c1);
    return c1 ? 8'h06 : 8'h00;
  endfunction

  // High-step correction: decimal ops fix the high nibble of AL (+/-60h),
  // ASCII ops carry/borrow a single unit into AH instead.
  function automatic logic [DATA_W-1:0] high_adj(input logic ascii,
                                                input logic c1,
                                                input logic c2);
    if (ascii) return c1 ? 8'h01 : 8'h00;
    return c2 ? 8'h60 : 8'h00;
  endfunction

  logic              accept;
  logic [1:0]        op_p0;
  logic [DATA_W-1:0] al_p0, ah_p0;
  logic              cf_p0, af_p0;
  logic [DATA_W-1:0] al1_p1;
  logic              cf1_p1;
  logic              c1, c2, dec_op, adj_en;

  assign in_ready  = !reset && (state == S_IDLE || (state == S_DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == S_DONE);

  assign c1     = (al_p0[3:0] > 4'd9) || af_p0;
  assign c2     = (al_p0 > 8'h99) || cf_p0;
  assign dec_op = !op_p0[1];
  // ASCII ops still run both steps when disabled, just with a zero addend.
  assign adj_en = dec_op || ASCII_EN;

  always_comb begin
    state_nxt = state;
    add_a     = '0;
    add_b     = '0;
    add_sub   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_LOW;
      end
      S_LOW: begin
        state_nxt = S_HIGH;
        add_a     = al_p0;
        add_sub   = op_p0[0];
        add_b     = adj_en ? low_adj(c1) : '0;
      end
      S_HIGH: begin
        state_nxt = S_DONE;
        add_a     = dec_op ? al1_p1 : ah_p0;
        add_sub   = op_p0[0];
        add_b     = adj_en ? high_adj(!dec_op, c1, c2) : '0;
      end
      S_DONE: begin
        if (out_ready) state_nxt = accept ? S_LOW : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // ---- p0: operand latch on accept ----
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0 <= in_op;
      al_p0 <= in_al;
      ah_p0 <= in_ah;
      cf_p0 <= in_cf;
      af_p0 <= in_af;
    end
  end

  // ---- p1: low-step result ----
  always_ff @(posedge clk) begin
    if (state == S_LOW) begin
      al1_p1 <= add_sum;
      cf1_p1 <= c1 && (cf_p0 || add_cout);
    end
  end

  // ---- p2: high-step result, held until writeback accepts ----
  always_ff @(posedge clk) begin
    if (reset) begin
      out_al         <= '0;
      out_ah         <= '0;
      out_cf         <= 1'b0;
      out_af         <= 1'b0;
      out_set_eflags <= '0;
    end else if (state == S_HIGH) begin
      if (dec_op) begin
        out_al         <= add_sum;
        out_ah         <= ah_p0;
        // A low-step carry on the add path implies AL >= FAh, so c2 already
        // covers it; the subtract path takes CF from c2 alone.
        out_cf         <= c2 || (cf1_p1 && !op_p0[0]);
        out_af         <= c1;
        out_set_eflags <= EF_DEC;
      end else if (ASCII_EN) begin
        out_al         <= {4'h0, al1_p1[3:0]};
        out_ah         <= add_sum;
        out_cf         <= c1;
        out_af         <= c1;
        out_set_eflags <= EF_ASC;
      end else begin
        out_al         <= al_p0;
        out_ah         <= ah_p0;
        out_cf         <= cf_p0;
        out_af         <= af_p0;
        out_set_eflags <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bcd_adjust_ctrl.sv
module tb_bcd_adjust_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_op = 2'd0;
  logic [7:0] in_al = 8'h00, in_ah = 8'h00;
  logic       in_cf = 1'b0, in_af = 1'b0;
  logic [7:0] add_a, add_b;
  logic       add_sub;
  logic [7:0] add_sum;
  logic       add_cout;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_al, out_ah;
  logic       out_cf, out_af;
  logic [5:0] out_set_eflags;

  always #5 clk = ~clk;

  // Behavioural shared adder/subtractor of the execute stage.
  logic [8:0] add_full;
  assign add_full = add_sub ? ({1'b0, add_a} - {1'b0, add_b}) : ({1'b0, add_a} + {1'b0, add_b});
  assign add_sum  = add_full[7:0];
  assign add_cout = add_full[8];

  bcd_adjust_ctrl #(.FLAG_W(6)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_al(in_al), .in_ah(in_ah), .in_cf(in_cf), .in_af(in_af),
    .add_a(add_a), .add_b(add_b), .add_sub(add_sub),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_al(out_al), .out_ah(out_ah), .out_cf(out_cf), .out_af(out_af),
    .out_set_eflags(out_set_eflags)
  );

  typedef struct {
    int         t;
    logic [7:0] lo_a, lo_b, hi_a, hi_b;
    logic       sub, chk_a, chk_sub;
    logic [7:0] al, ah;
    logic       cf, af;
    logic [5:0] ef;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   last_acc = -100;
  int   acc_gap = 0;
  bit   rst_seen = 0;
  bit   stall = 0;
  bit   rnd_rdy = 0;

  // x86 decimal-adjust semantics in plain integer arithmetic.
  function automatic exp_t model(input logic [1:0] op, input logic [7:0] al,
                                 input logic [7:0] ah, input logic cf, input logic af);
    exp_t e;
    int   lo, hi, a, h;
    bit   c1, c2;
    c1 = ((int'(al) % 16) > 9) || af;
    c2 = (int'(al) > 153) || cf;
    e.t = 0; e.chk_a = 1; e.chk_sub = 1; e.sub = op[0];
    e.lo_a = al;
    if (!op[1]) begin
      lo = c1 ? 6 : 0;
      hi = c2 ? 96 : 0;
      a  = op[0] ? (int'(al) - lo) : (int'(al) + lo);
      a  = a & 255;
      h  = op[0] ? (a - hi) : (a + hi);
      e.lo_b = 8'(lo); e.hi_a = 8'(a); e.hi_b = 8'(hi);
      e.al = 8'(h & 255); e.ah = ah; e.cf = c2; e.af = c1; e.ef = 6'b011111;
    end else begin
`ifdef BCD_ASCII_ADJUST_EN
      lo = c1 ? 6 : 0;
      hi = c1 ? 1 : 0;
      a  = op[0] ? (int'(al) - lo) : (int'(al) + lo);
      h  = op[0] ? (int'(ah) - hi) : (int'(ah) + hi);
      e.lo_b = 8'(lo); e.hi_a = ah; e.hi_b = 8'(hi);
      e.al = 8'(a & 15); e.ah = 8'(h & 255); e.cf = c1; e.af = c1; e.ef = 6'b000101;
`else
      e.chk_a = 0; e.chk_sub = 0;
      e.lo_b = 8'h00; e.hi_a = ah; e.hi_b = 8'h00;
      e.al = al; e.ah = ah; e.cf = cf; e.af = af; e.ef = 6'b000000;
`endif
    end
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, req);
    end
  endtask

  // Accept tracker: stamps each handshake and pushes its expected response.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      q.delete();
      rst_seen = 1;
    end else if (in_valid && in_ready) begin
      exp_t e;
      e = model(in_op, in_al, in_ah, in_cf, in_af);
      e.t = cyc;
      q.push_back(e);
      acc_gap  = cyc - last_acc;
      last_acc = cyc;
    end
  end

  // Monitor: LOW is the cycle after the accept edge, HIGH the next, then DONE.
  always @(negedge clk) begin
    bit exp_ov, exp_ir;
    exp_ov = (q.size() > 0) && (cyc >= q[0].t + 2);
    exp_ir = !reset && ((q.size() == 0) || (exp_ov && out_ready));
    chk("in_ready", int'(in_ready), int'(exp_ir));
    chk("out_valid", int'(out_valid), int'(exp_ov));
    if (rst_seen) begin
      chk("rst_out_al", int'(out_al), 0);
      chk("rst_out_ah", int'(out_ah), 0);
      chk("rst_out_flags", int'({out_cf, out_af, out_set_eflags}), 0);
      rst_seen = 0;
    end
    if (q.size() > 0 && cyc == q[0].t) begin
      if (q[0].chk_a)   chk("low_add_a", int'(add_a), int'(q[0].lo_a));
      if (q[0].chk_sub) chk("low_add_sub", int'(add_sub), int'(q[0].sub));
      chk("low_add_b", int'(add_b), int'(q[0].lo_b));
    end else if (q.size() > 0 && cyc == q[0].t + 1) begin
      if (q[0].chk_a)   chk("high_add_a", int'(add_a), int'(q[0].hi_a));
      if (q[0].chk_sub) chk("high_add_sub", int'(add_sub), int'(q[0].sub));
      chk("high_add_b", int'(add_b), int'(q[0].hi_b));
    end else begin
      chk("idle_add", int'({add_sub, add_a, add_b}), 0);
    end
    if (exp_ov && out_valid) begin
      chk("out_al", int'(out_al), int'(q[0].al));
      chk("out_ah", int'(out_ah), int'(q[0].ah));
      chk("out_cf", int'(out_cf), int'(q[0].cf));
      chk("out_af", int'(out_af), int'(q[0].af));
      chk("out_eflags", int'(out_set_eflags), int'(q[0].ef));
      if (out_ready) void'(q.pop_front());
    end
  end

  // out_ready driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall)        out_ready = 1'b0;
      else if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      else              out_ready = 1'b1;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] al, input logic [7:0] ah,
                       input logic cf, input logic af, input bit keep);
    int  n;
    bit  done;
    in_valid = 1'b1; in_op = op; in_al = al; in_ah = ah; in_cf = cf; in_af = af;
    n = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1;
      else if (++n > 60) begin
        failures++;
        $display("FAIL accept_timeout cyc=%0d got=in_ready_low expected=accept", cyc);
        done = 1;
      end
    end
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d expected=0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Directed cases.
    issue(2'b00, 8'h3C, 8'h11, 1'b0, 1'b0, 0);
    issue(2'b00, 8'h9A, 8'h22, 1'b0, 1'b0, 0);
    issue(2'b01, 8'h2D, 8'h33, 1'b0, 1'b1, 0);
    issue(2'b10, 8'h0F, 8'h00, 1'b0, 1'b0, 0);
    issue(2'b11, 8'h0F, 8'h05, 1'b0, 1'b0, 0);
    issue(2'b10, 8'h34, 8'h07, 1'b1, 1'b0, 0);
    issue(2'b01, 8'h00, 8'h00, 1'b1, 1'b0, 0);
    issue(2'b00, 8'hFF, 8'hFF, 1'b1, 1'b1, 0);
    wait_drain();

    // Writeback stall for five cycles, then reset during the HIGH step.
    stall = 1;
    issue(2'b00, 8'h47, 8'h10, 1'b0, 1'b0, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall_reached_done", int'(out_valid), 1);
    repeat (5) @(negedge clk);
    stall = 0;
    wait_drain();
    issue(2'b01, 8'h99, 8'h01, 1'b1, 1'b1, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back stream with in_valid held high.
    issue(2'b00, 8'h19, 8'h00, 1'b0, 1'b0, 1);
    issue(2'b00, 8'h5A, 8'h01, 1'b0, 1'b0, 1);
    chk("b2b_gap1", acc_gap, 3);
    issue(2'b00, 8'hA0, 8'h02, 1'b0, 1'b0, 1);
    chk("b2b_gap2", acc_gap, 3);
    issue(2'b00, 8'h88, 8'h03, 1'b1, 1'b1, 0);
    chk("b2b_gap3", acc_gap, 3);
    wait_drain();

    // Random traffic with random writeback backpressure.
    rnd_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      issue(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    rnd_rdy = 0;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
